// File: rtl/serial_subtractor.sv
// serial_subtractor
// -----------------
// Bit-serial subtractor: D = A - B computed LSB first over WIDTH clock
// cycles with one full-subtractor cell and a borrow flip-flop.
//
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed overflow output
// `ovf` together with the captured operand MSBs it needs.
//
// Handshake: `start` is accepted on a rising edge while the block is IDLE or
// DONE; it is ignored during RUN. `done` is a one-cycle pulse that marks the
// cycle in which `d`, `bout` (and `ovf`) have just been updated. Those
// result outputs hold their value until the next operation completes.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   request a subtraction
//   a          in   minuend   [WIDTH-1:0], captured on accepted start
//   b          in   subtrahend [WIDTH-1:0], captured on accepted start
//   busy       out  high while in RUN
//   done       out  high for the single cycle spent in DONE
//   d          out  (a - b) mod 2^WIDTH
//   bout       out  final borrow, 1 when a < b unsigned
//   state_dbg  out  current FSM state encoding (0 IDLE, 1 RUN, 2 DONE)
//   ovf        out  two's-complement overflow of a - b (SERIAL_SUB_OVF_EN only)
//
// All outputs come straight from registers; there is no combinational path
// from any input to any output.

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic [1:0]       state_dbg
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             step;
  logic             last;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic             br;
  logic             br_nxt;
  logic             diff;
  logic [CNT_W-1:0] cnt;

`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  // Next-state and control decode.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (cnt == LAST_BIT) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Full-subtractor cell on the current LSBs of the operand shifters.
  always_comb begin
    diff    = a_sh[0] ^ b_sh[0] ^ br;
    br_nxt  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    // diff enters the result from the MSB side; after WIDTH steps the first
    // computed bit has travelled down to bit 0. The extended shift keeps this
    // legal for WIDTH = 1.
    res_nxt = WIDTH'({diff, res} >> 1);
    last    = step && (cnt == LAST_BIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      d     <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (load) begin
        a_sh  <= a;
        b_sh  <= b;
        res   <= '0;
        br    <= 1'b0;
        cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
`endif
      end else if (step) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        res  <= res_nxt;
        br   <= br_nxt;
        cnt  <= cnt + CNT_W'(1);
      end
      // Results are published only on the edge that finishes the last bit,
      // so they stay stable through RUN and between operations.
      if (last) begin
        d    <= res_nxt;
        bout <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
        // res_nxt[WIDTH-1] is the difference MSB computed on this edge.
        ovf  <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
`endif
      end
    end
  end

  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a WIDTH=8 instance exercised through a result
// scoreboard, plus a WIDTH=1 instance for the single-bit corner.

module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] d;
  logic       bout;
  logic [1:0] state_dbg;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [0:0] d1;
  logic       bout1;
  logic [1:0] state_dbg1;

`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
  logic       ovf1;
`endif

  int checks = 0;
  int errors = 0;

  // Scoreboard: {bout, d} expected per accepted operation, ovf in a side queue.
  logic [8:0] exp_q[$];
  logic       ovf_q[$];
  logic [7:0] last_d;

  serial_subtractor #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .d(d), .bout(bout), .state_dbg(state_dbg)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .d(d1), .bout(bout1), .state_dbg(state_dbg1)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf1)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model / driver ----------------
  function automatic logic [8:0] model_sub(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] r;
    r = {1'b0, x} - {1'b0, y};
    return r;
  endfunction

  function automatic logic model_ovf(input logic [7:0] x, input logic [7:0] y);
    int sd;
    sd = int'($signed(x)) - int'($signed(y));
    return (sd > 127) || (sd < -128);
  endfunction

  task automatic push_exp(input logic [7:0] x, input logic [7:0] y);
    exp_q.push_back(model_sub(x, y));
    ovf_q.push_back(model_ovf(x, y));
  endtask

  // Called #1 after an edge; returns #1 after the edge that samples start.
  task automatic drive_start(input logic [7:0] x, input logic [7:0] y);
    start = 1'b1;
    a     = x;
    b     = y;
    push_exp(x, y);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen; n = -1 if the budget runs out.
  task automatic wait_done(input int max_edges, output int n);
    n = -1;
    for (int i = 1; i <= max_edges; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic pop_exp(output logic [8:0] e, output logic eo, output bit ok);
    ok = (exp_q.size() > 0);
    e  = '0;
    eo = 1'b0;
    if (ok) begin
      e  = exp_q.pop_front();
      eo = ovf_q.pop_front();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, bout, d, state_dbg} !== 13'd0) begin
      errors++;
      $display("FAIL reset_w8: busy=%b done=%b bout=%b d=%h state=%0d, required all 0",
               busy, done, bout, d, state_dbg);
    end
    checks++;
    if ({busy1, done1, bout1, d1} !== 4'd0) begin
      errors++;
      $display("FAIL reset_w1: busy=%b done=%b bout=%b d=%b, required all 0",
               busy1, done1, bout1, d1);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b required 0", ovf);
    end
`endif
    rst    = 1'b0;
    last_d = 8'h00;
  endtask

  task automatic test_basic();
    logic [7:0] av[6];
    logic [7:0] bv[6];
    logic [8:0] e;
    logic       eo;
    bit         ok;
    int         n;
    av = '{8'h5A, 8'h10, 8'h80, 8'h00, 8'h00, 8'h00};
    bv = '{8'h23, 8'h20, 8'h01, 8'h00, 8'h00, 8'h00};
    av[4] = 8'($urandom_range(0, 255)); bv[4] = 8'($urandom_range(0, 255));
    av[5] = 8'($urandom_range(0, 255)); bv[5] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 6; i++) begin
      drive_start(av[i], bv[i]);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_busy[%0d]: got %b required 1", i, busy);
      end
      wait_done(20, n);
      checks++;
      if (n != 8) begin
        errors++;
        $display("FAIL basic_latency[%0d]: got %0d edges required 8", i, n);
      end
      pop_exp(e, eo, ok);
      checks++;
      if (!ok || {bout, d} !== e) begin
        errors++;
        $display("FAIL basic_result[%0d] a=%h b=%h: got bout=%b d=%h required bout=%b d=%h",
                 i, av[i], bv[i], bout, d, e[8], e[7:0]);
      end
`ifdef SERIAL_SUB_OVF_EN
      checks++;
      if (ovf !== eo) begin
        errors++;
        $display("FAIL basic_ovf[%0d]: got %b required %b", i, ovf, eo);
      end
`endif
      last_d = e[7:0];
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || d !== e[7:0]) begin
        errors++;
        $display("FAIL basic_after[%0d]: done=%b busy=%b d=%h required done=0 busy=0 d=%h",
                 i, done, busy, d, e[7:0]);
      end
    end
  endtask

  task automatic test_ignore_while_busy();
    logic [8:0] e;
    logic       eo;
    bit         ok;
    int         n;
    drive_start(8'hFF, 8'h01);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || d !== last_d) begin
      errors++;
      $display("FAIL ignore_hold: busy=%b d=%h required busy=1 d=%h", busy, d, last_d);
    end
    // This request lands on the 4th RUN edge and must be dropped.
    start = 1'b1;
    a     = 8'h00;
    b     = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(20, n);
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL ignore_latency: got %0d edges required 4", n);
    end
    pop_exp(e, eo, ok);
    checks++;
    if (!ok || {bout, d} !== e) begin
      errors++;
      $display("FAIL ignore_result: got bout=%b d=%h required bout=%b d=%h",
               bout, d, e[8], e[7:0]);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf !== eo) begin
      errors++;
      $display("FAIL ignore_ovf: got %b required %b", ovf, eo);
    end
`endif
    last_d = e[7:0];
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_second: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] av[4];
    logic [7:0] bv[4];
    logic [8:0] e;
    logic       eo;
    bit         ok;
    int         n;
    av = '{8'h01, 8'h7F, 8'h00, 8'h00};
    bv = '{8'h02, 8'h80, 8'h00, 8'h00};
    for (int i = 2; i < 4; i++) begin
      av[i] = 8'($urandom_range(0, 255));
      bv[i] = 8'($urandom_range(0, 255));
    end
    start = 1'b1;
    a     = av[0];
    b     = bv[0];
    push_exp(av[0], bv[0]);
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) begin
      wait_done(20, n);
      checks++;
      if (n != ((j == 0) ? 8 : 9)) begin
        errors++;
        $display("FAIL b2b_spacing[%0d]: got %0d edges required %0d", j, n, (j == 0) ? 8 : 9);
      end
      pop_exp(e, eo, ok);
      checks++;
      if (!ok || {bout, d} !== e) begin
        errors++;
        $display("FAIL b2b_result[%0d]: got bout=%b d=%h required bout=%b d=%h",
                 j, bout, d, e[8], e[7:0]);
      end
`ifdef SERIAL_SUB_OVF_EN
      checks++;
      if (ovf !== eo) begin
        errors++;
        $display("FAIL b2b_ovf[%0d]: got %b required %b", j, ovf, eo);
      end
`endif
      last_d = e[7:0];
      if (j < 3) begin
        a = av[j+1];
        b = bv[j+1];
        push_exp(av[j+1], bv[j+1]);
      end else begin
        start = 1'b0;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [8:0] e;
    logic       eo;
    bit         ok;
    int         n;
    drive_start(8'h33, 8'h44);
    void'(exp_q.pop_back());
    void'(ovf_q.pop_back());
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || d !== 8'h00 || bout !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state: busy=%b done=%b d=%h bout=%b required 0 0 00 0",
               busy, done, d, bout);
    end
    wait_done(12, n);
    checks++;
    if (n != -1) begin
      errors++;
      $display("FAIL rst_mid_no_done: done seen after %0d edges, required none", n);
    end
    drive_start(8'h33, 8'h44);
    wait_done(20, n);
    pop_exp(e, eo, ok);
    checks++;
    if (n != 8 || !ok || {bout, d} !== e) begin
      errors++;
      $display("FAIL rst_mid_recover: edges=%0d bout=%b d=%h required edges=8 bout=%b d=%h",
               n, bout, d, e[8], e[7:0]);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf !== eo) begin
      errors++;
      $display("FAIL rst_mid_ovf: got %b required %b", ovf, eo);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_width1();
    logic ex_d;
    logic ex_b;
    for (int i = 0; i < 4; i++) begin
      start1 = 1'b1;
      a1     = 1'(i >> 1);
      b1     = 1'(i);
      ex_d   = a1[0] ^ b1[0];
      ex_b   = ~a1[0] & b1[0];
      @(posedge clk); #1;
      start1 = 1'b0;
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        errors++;
        $display("FAIL w1_busy[%0d]: busy=%b done=%b required 1 0", i, busy1, done1);
      end
      @(posedge clk); #1;
      checks++;
      if (done1 !== 1'b1 || d1[0] !== ex_d || bout1 !== ex_b) begin
        errors++;
        $display("FAIL w1_result[%0d] a=%b b=%b: done=%b d=%b bout=%b required 1 %b %b",
                 i, a1, b1, done1, d1, bout1, ex_d, ex_b);
      end
`ifdef SERIAL_SUB_OVF_EN
      checks++;
      if (ovf1 !== ((a1[0] != b1[0]) && (ex_d != a1[0]))) begin
        errors++;
        $display("FAIL w1_ovf[%0d]: got %b", i, ovf1);
      end
`endif
      @(posedge clk); #1;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
    a      = '0;
    b      = '0;
    a1     = '0;
    b1     = '0;
    test_reset();
    test_basic();
    test_ignore_while_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
